// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Instruction-fetch unit for the MIPS32 core. Owns the PC and issues one word
//   read per cycle to a synchronous instruction ROM (1-cycle latency). Returned
//   words are pushed into a DEPTH-entry prefetch queue that feeds decode. A
//   redirect from execute flushes the queue, kills the in-flight read and
//   restarts fetch at the target.
//
//   Handshake: the head entry transfers on any rising edge where out_valid and
//   out_ready are both high. out_valid never drops without a transfer, except
//   on a redirect or reset, and the head fields are held stable while it is
//   waiting.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   imem_en, imem_addr        ROM read request (word address = PC[ADDR_W-1:2])
//   imem_rdata                ROM data, valid the cycle after imem_en
//   redirect_valid/_pc        one-cycle restart request with byte target
//   out_valid/out_ready       head-of-queue handshake toward decode
//   out_instr, out_pc         head instruction word and its byte PC
//   out_pc_plus_4             out_pc + 4 (wraps)
//   misalign_err              one-cycle pulse after a redirect with pc[1:0] != 0
//   dbg_state                 FSM state: 0 = BOOT, 1 = RUN

module ifetch_prefetch #(
   parameter int          ADDR_W   = 16,
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              imem_en,
   output logic [ADDR_W-3:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_pc_plus_4,
   output logic              misalign_err,
   output logic              dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [31:0]        pc_q;
   logic [CNT_W-1:0]   count_q;
   logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
   logic               inflight_q;
   logic [31:0]        tag_q;
   logic               misalign_q;

   logic [31:0]        instr_mem [DEPTH];
   logic [31:0]        pc_mem    [DEPTH];

   logic [31:0]        redir_aligned;
   logic               redirect_run;
   logic               pop;
   logic               push;
   logic               issue;
   logic [CNT_W-1:0]   fill;
   logic [31:0]        issue_pc;

   // FSM: BOOT lasts one cycle, only reset brings it back.
   always_ff @(posedge clock) begin
      if (reset) state_q <= BOOT;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   always_comb begin
      redir_aligned = {redirect_pc[31:2], 2'b00};
      redirect_run  = (state_q == RUN) && redirect_valid;
      pop           = out_valid && out_ready;
      // A response arriving in a redirect cycle belongs to the old stream.
      push          = inflight_q && !redirect_run;
      // The in-flight read reserves a slot; a same-cycle pop does not free one.
      fill          = count_q + CNT_W'(inflight_q);
      issue         = !reset && (state_q == RUN) &&
                      (redirect_valid || (fill < CNT_W'(DEPTH)));
      issue_pc      = redirect_run ? redir_aligned : pc_q;
   end

   assign imem_en   = issue;
   assign imem_addr = issue_pc[ADDR_W-1:2];

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         inflight_q <= 1'b0;
         tag_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         inflight_q <= issue;
         if (issue) begin
            pc_q  <= issue_pc + 32'd4;
            tag_q <= issue_pc;
         end else if (state_q == BOOT && redirect_valid) begin
            // Redirect seen before the first issue: just retarget the PC.
            pc_q  <= redir_aligned;
         end

         if (redirect_run) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Queue storage needs no reset; count_q qualifies every entry.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         instr_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]    <= tag_q;
      end
   end

   assign out_valid     = (count_q != '0);
   assign out_instr     = instr_mem[rd_ptr_q];
   assign out_pc        = pc_mem[rd_ptr_q];
   assign out_pc_plus_4 = out_pc + 32'd4;
   assign misalign_err  = misalign_q;
   assign dbg_state     = (state_q == RUN);

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch
//   Directed bench for ifetch_prefetch with a behavioural 1-cycle ROM whose
//   contents are a fixed function of the word address.
//   Cycle 0 is the first cycle after reset is released (FSM in BOOT). Inputs
//   are driven on the falling edge and outputs sampled 1 ns later.

module tb_ifetch_prefetch;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              imem_en;
   logic [ADDR_W-3:0] imem_addr;
   logic [31:0]       imem_rdata = '0;
   logic              redirect_valid = 1'b0;
   logic [31:0]       redirect_pc = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc;
   logic [31:0]       out_pc_plus_4;
   logic              misalign_err;
   logic              dbg_state;

   int n_checks = 0;
   int n_bad    = 0;
   logic [31:0] exp_q[$];

   ifetch_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus_4  (out_pc_plus_4),
      .misalign_err   (misalign_err),
      .dbg_state      (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   // ---------------- ROM model ----------------
   function automatic logic [31:0] rom_word(input logic [13:0] w);
      return {2'b10, w, ~w, 2'b01};
   endfunction

   always @(posedge clock) begin
      if (imem_en) imem_rdata <= rom_word(imem_addr);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc);
      logic [31:0] pc4;
      pc4 = pc + 32'd4;
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_pc"},    out_pc, pc);
      check({tag, "_instr"}, out_instr, rom_word(pc[15:2]));
      check({tag, "_pc4"},   out_pc_plus_4, pc4);
   endtask

   // Fill level must never exceed DEPTH.
   always @(negedge clock) begin
      if (!reset) check("fill_le_depth", {31'b0, (dut.count_q <= 3'(DEPTH))}, 32'd1);
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
      @(negedge clock);
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      #100000;
      n_bad++;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      // Test 1: reset state, then steady stream from PC 0
      do_reset();
      out_ready = 1'b1;
      #1;
      check("rst_valid", {31'b0, out_valid}, 32'd0);
      check("rst_en",    {31'b0, imem_en}, 32'd0);
      check("rst_mis",   {31'b0, misalign_err}, 32'd0);
      check("rst_state", {31'b0, dbg_state}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1);                       // cycle 1
      check("t1_en_c1",   {31'b0, imem_en}, 32'd1);
      check("t1_addr_c1", {18'b0, imem_addr}, 32'd0);
      check("t1_state",   {31'b0, dbg_state}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1);                       // cycle 2
      check("t1_valid_c2", {31'b0, out_valid}, 32'd0);
      check("t1_addr_c2",  {18'b0, imem_addr}, 32'd1);
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      while (exp_q.size() > 0) begin               // cycles 3..8
         cyc(1'b0, 32'h0, 1'b1);
         check_head("t1_head", exp_q.pop_front());
         check("t1_en", {31'b0, imem_en}, 32'd1);
      end

      // Test 2: stall 10 cycles, queue fills, then drains without gaps
      for (int i = 0; i < 10; i++) begin           // cycles 9..18
         cyc(1'b0, 32'h0, 1'b0);
         check_head("t2_hold", 32'h18);
         check("t2_en", {31'b0, imem_en}, (i >= 2) ? 32'd0 : 32'd1);
      end
      for (int i = 0; i < 6; i++) exp_q.push_back(32'h18 + 32'(i * 4));
      while (exp_q.size() > 0) begin               // cycles 19..24
         cyc(1'b0, 32'h0, 1'b1);
         check_head("t2_drain", exp_q.pop_front());
      end

      // Test 3: BOOT redirect to 0x10, fill 0x10..0x1C, redirect to 0x40
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h10;
      #1;
      check("t3_boot_en", {31'b0, imem_en}, 32'd0);
      cyc(1'b0, 32'h0, 1'b0);                       // cycle 1
      check("t3_addr_c1", {18'b0, imem_addr}, 32'd4);
      repeat (5) cyc(1'b0, 32'h0, 1'b0);            // cycles 2..6
      check_head("t3_full", 32'h10);
      check("t3_full_en", {31'b0, imem_en}, 32'd0);
      cyc(1'b1, 32'h40, 1'b0);                      // t = 7
      check("t3_redir_en",   {31'b0, imem_en}, 32'd1);
      check("t3_redir_addr", {18'b0, imem_addr}, 32'h10);
      cyc(1'b0, 32'h0, 1'b0);                       // t+1
      check("t3_flushed", {31'b0, out_valid}, 32'd0);
      check("t3_addr_t1", {18'b0, imem_addr}, 32'h11);
      check("t3_mis",     {31'b0, misalign_err}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1);                       // t+2
      check_head("t3_new", 32'h40);
      cyc(1'b0, 32'h0, 1'b1);
      check_head("t3_next", 32'h44);

      // Test 4: misaligned redirect to 0x46 (handshake on 0x48 same cycle)
      cyc(1'b1, 32'h46, 1'b1);                      // t
      check_head("t4_head", 32'h48);
      check("t4_addr",  {18'b0, imem_addr}, 32'h11);
      check("t4_mis_t", {31'b0, misalign_err}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1);                       // t+1
      check("t4_mis_t1",   {31'b0, misalign_err}, 32'd1);
      check("t4_valid_t1", {31'b0, out_valid}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1);                       // t+2
      check("t4_mis_t2", {31'b0, misalign_err}, 32'd0);
      check_head("t4_resume", 32'h44);

      // Test 5: redirect + handshake, then a second redirect to 0x80
      cyc(1'b1, 32'h60, 1'b1);                      // u: 0x48 consumed here
      check_head("t5_head", 32'h48);
      check("t5_addr_u", {18'b0, imem_addr}, 32'h18);
      cyc(1'b1, 32'h80, 1'b1);                      // u+1
      check("t5_valid_u1", {31'b0, out_valid}, 32'd0);
      check("t5_addr_u1",  {18'b0, imem_addr}, 32'h20);
      check("t5_en_u1",    {31'b0, imem_en}, 32'd1);
      cyc(1'b0, 32'h0, 1'b1);                       // u+2
      check("t5_valid_u2", {31'b0, out_valid}, 32'd0);
      cyc(1'b0, 32'h0, 1'b1);                       // u+3
      check_head("t5_new", 32'h80);
      cyc(1'b0, 32'h0, 1'b1);
      check_head("t5_next", 32'h84);

      // Test 6a: reset with a full queue
      repeat (6) cyc(1'b0, 32'h0, 1'b0);
      check("t6_full_en",    {31'b0, imem_en}, 32'd0);
      check("t6_full_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("t6_en_in_rst", {31'b0, imem_en}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("t6_valid_after", {31'b0, out_valid}, 32'd0);
      check("t6_en_after",    {31'b0, imem_en}, 32'd0);
      check("t6_state_after", {31'b0, dbg_state}, 32'd0);

      // Test 6b: PC wrap from 0xFFFFFFFC
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      #1;
      cyc(1'b0, 32'h0, 1'b0);                       // cycle 1
      check("t6_addr_top",  {18'b0, imem_addr}, 32'h3FFF);
      cyc(1'b0, 32'h0, 1'b0);                       // cycle 2
      check("t6_addr_wrap", {18'b0, imem_addr}, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);                       // cycle 3
      check_head("t6_top", 32'hFFFF_FFFC);
      check("t6_wrap_p4", out_pc_plus_4, 32'h0);
      cyc(1'b0, 32'h0, 1'b1);
      check_head("t6_zero", 32'h0);

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
